// File: rtl/pc_pkg.sv
// Program-counter package: next-PC source encoding and the sequential
// instruction increment. Imported by the interface, top and bench.
package pc_pkg;

   typedef enum logic [2:0] {
      INC    = 3'd0,
      BRANCH = 3'd1,
      JALR   = 3'd2,
      TRAP   = 3'd3,
      RET    = 3'd4
   } pc_sel_t;

   localparam int PC_INC = 4;

endpackage

// File: rtl/pc_unit_if.sv
// Front-end control bundle between the decode/execute side (master) and the
// PC unit (slave).
//   master drives : stall, pc_sel, imm_op, rs1_val, trap_vec, ras_push
//   slave drives  : pc, pc_plus4, misalign, ras_underflow
interface pc_unit_if #(
   parameter int PC_WIDTH = 32
);
   import pc_pkg::*;

   logic                stall;
   pc_sel_t             pc_sel;
   logic [PC_WIDTH-1:0] imm_op;
   logic [PC_WIDTH-1:0] rs1_val;
   logic [PC_WIDTH-1:0] trap_vec;
   logic                ras_push;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] pc_plus4;
   logic                misalign;
   logic                ras_underflow;

   modport master (
      output stall, pc_sel, imm_op, rs1_val, trap_vec, ras_push,
      input  pc, pc_plus4, misalign, ras_underflow
   );

   modport slave (
      input  stall, pc_sel, imm_op, rs1_val, trap_vec, ras_push,
      output pc, pc_plus4, misalign, ras_underflow
   );

endinterface

// File: rtl/pc_ras.sv
// Return-address stack, circular storage of DEPTH entries.
//   clk, rst  : clock, synchronous active-high reset (drops all entries)
//   push      : write push_val as new top (overwrites oldest when full)
//   pop       : remove top (ignored when empty)
//   push+pop  : replace top with push_val, count unchanged
//   top       : current top entry (meaningless when empty)
//   empty     : no valid entries
//   count     : number of valid entries, 0..DEPTH
module pc_ras #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         push_val,
   output logic [WIDTH-1:0]         top,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [PW-1:0]               wp;    // next free slot
   logic [PW-1:0]               tp;    // slot holding the top
   logic [CW-1:0]               cnt;
   logic                        do_pop;

   // DEPTH is a power of two, so pointer wrap naturally recycles the oldest slot.
   assign tp     = wp - 1'b1;
   assign top    = mem[tp];
   assign empty  = (cnt == '0);
   assign count  = cnt;
   assign do_pop = pop && !empty;

   // Entry storage is not cleared on reset; cnt alone defines validity.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp  <= '0;
         cnt <= '0;
      end else begin
         case ({push, do_pop})
            2'b10: begin
               mem[wp] <= push_val;
               wp      <= wp + 1'b1;
               if (cnt != CW'(DEPTH)) cnt <= cnt + 1'b1;
            end
            2'b01: begin
               wp  <= tp;
               cnt <= cnt - 1'b1;
            end
            2'b11: mem[tp] <= push_val;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC selection, misalignment trap redirect and an
// optional return-address stack.
//   clk, rst : clock, synchronous active-high reset (overrides stall)
//   bus      : pc_unit_if slave (stall, pc_sel, imm_op, rs1_val, trap_vec,
//              ras_push in; pc, pc_plus4, misalign, ras_underflow out)
// Build option: define PC_UNIT_RAS_EN to build the RAS and RET behaviour;
// otherwise RET acts as INC, ras_push is ignored and ras_underflow is 0.
module pc_unit
   import pc_pkg::*;
#(
   parameter int                  PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
   parameter int                  RAS_DEPTH    = 4
) (
   input logic       clk,
   input logic       rst,
   pc_unit_if.slave  bus
);
   logic [PC_WIDTH-1:0] pc_q;
   logic [PC_WIDTH-1:0] inc;
   logic [PC_WIDTH-1:0] jalr_sum;
   logic [PC_WIDTH-1:0] tgt;
   logic [PC_WIDTH-1:0] nxt;
   logic                bad;
   logic                mis_q;

   assign inc      = pc_q + PC_WIDTH'(PC_INC);
   assign jalr_sum = bus.rs1_val + bus.imm_op;

`ifdef PC_UNIT_RAS_EN
   logic [PC_WIDTH-1:0]        ras_top;
   logic                       ras_empty;
   logic [$clog2(RAS_DEPTH):0] ras_count_unused;
   logic                       ret_sel;
   logic                       unf_q;

   assign ret_sel = (bus.pc_sel == RET);

   pc_ras #(
      .WIDTH (PC_WIDTH),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk      (clk),
      .rst      (rst),
      .push     (bus.ras_push && !bus.stall),
      .pop      (ret_sel && !bus.stall),
      .push_val (inc),
      .top      (ras_top),
      .empty    (ras_empty),
      .count    (ras_count_unused)
   );
`else
   localparam int unused_ras_depth = RAS_DEPTH;
   logic unused_ras_push;
   assign unused_ras_push = bus.ras_push;
`endif

   always_comb begin
      tgt = inc;
      case (bus.pc_sel)
         BRANCH:  tgt = pc_q + bus.imm_op;
         JALR:    tgt = {jalr_sum[PC_WIDTH-1:1], 1'b0};
         TRAP:    tgt = bus.trap_vec;
`ifdef PC_UNIT_RAS_EN
         RET:     tgt = ras_empty ? inc : ras_top;
`endif
         default: tgt = inc;
      endcase
   end

   // trap_vec is trusted as-is; any other misaligned target redirects to it.
   assign bad = (bus.pc_sel != TRAP) && (tgt[1:0] != 2'b00);
   assign nxt = bad ? bus.trap_vec : tgt;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q  <= RESET_VECTOR;
         mis_q <= 1'b0;
      end else if (bus.stall) begin
         mis_q <= 1'b0;
      end else begin
         pc_q  <= nxt;
         mis_q <= bad;
      end
   end

`ifdef PC_UNIT_RAS_EN
   always_ff @(posedge clk) begin
      if (rst || bus.stall) unf_q <= 1'b0;
      else                  unf_q <= ret_sel && ras_empty;
   end
   assign bus.ras_underflow = unf_q;
`else
   assign bus.ras_underflow = 1'b0;
`endif

   assign bus.pc       = pc_q;
   assign bus.pc_plus4 = inc;
   assign bus.misalign = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
   import pc_pkg::*;

`ifdef PC_UNIT_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pc_unit_if #(.PC_WIDTH(32)) bus ();

   pc_unit #(
      .PC_WIDTH     (32),
      .RESET_VECTOR (32'h0),
      .RAS_DEPTH    (DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int passed = 0;
   int total  = 0;
   int failed = 0;

   // Reference state: architectural PC, stack as a queue (back = top).
   logic [31:0] m_pc = 32'h0;
   logic [31:0] m_stk[$];
   logic        m_mis = 1'b0;
   logic        m_unf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference next-state from the rules, written as plain arithmetic.
   task automatic model(input logic r, input logic st, input logic [2:0] sel,
                        input logic [31:0] imm, input logic [31:0] rs1,
                        input logic [31:0] tv, input logic push);
      logic [31:0] tgt;
      logic [31:0] link;
      logic        is_ret;
      if (r) begin
         m_pc = 32'h0; m_stk.delete(); m_mis = 0; m_unf = 0;
         return;
      end
      if (st) begin
         m_mis = 0; m_unf = 0;
         return;
      end
      link   = m_pc + 32'd4;
      is_ret = RAS_EN && (sel == 3'd4);
      case (sel)
         3'd1:    tgt = m_pc + imm;
         3'd2:    tgt = (rs1 + imm) & 32'hFFFF_FFFE;
         3'd3:    tgt = tv;
         3'd4:    tgt = (is_ret && m_stk.size() > 0) ? m_stk[$] : link;
         default: tgt = link;
      endcase
      m_unf = is_ret && (m_stk.size() == 0);
      if (is_ret && m_stk.size() > 0) void'(m_stk.pop_back());
      if (RAS_EN && push) begin
         m_stk.push_back(link);
         if (m_stk.size() > DEPTH) void'(m_stk.pop_front());
      end
      m_mis = (sel != 3'd3) && (tgt[1:0] != 2'b00);
      m_pc  = m_mis ? tv : tgt;
   endtask

   task automatic step(input string tag, input logic r, input logic st,
                       input logic [2:0] sel, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] tv,
                       input logic push);
      rst          = r;
      bus.stall    = st;
      bus.pc_sel   = pc_sel_t'(sel);
      bus.imm_op   = imm;
      bus.rs1_val  = rs1;
      bus.trap_vec = tv;
      bus.ras_push = push;
      model(r, st, sel, imm, rs1, tv, push);
      @(posedge clk);
      #1;
      chk({tag, ".pc"},       bus.pc,                    m_pc);
      chk({tag, ".pc_plus4"}, bus.pc_plus4,              m_pc + 32'd4);
      chk({tag, ".misalign"}, {31'b0, bus.misalign},      {31'b0, m_mis});
      chk({tag, ".underflow"},{31'b0, bus.ras_underflow}, {31'b0, m_unf});
   endtask

   initial begin
      logic [2:0]  sel;
      logic [31:0] imm;
      bus.stall = 0; bus.pc_sel = INC; bus.imm_op = 0; bus.rs1_val = 0;
      bus.trap_vec = 0; bus.ras_push = 0;
      @(posedge clk); #1;

      // reset, then sequential fetch
      step("reset",  1, 0, 3'd0, 0, 0, 0, 0);
      chk("reset_pc_const", bus.pc, 32'h0);
      step("inc1",   0, 0, 3'd0, 0, 0, 0, 0);
      step("inc2",   0, 0, 3'd0, 0, 0, 0, 0);
      step("inc3",   0, 0, 3'd0, 0, 0, 0, 0);
      chk("inc3_const", bus.pc, 32'hC);

      // backward branch and JALR bit0 clear
      step("trap100", 0, 0, 3'd3, 0, 0, 32'h100, 0);
      step("br_neg",  0, 0, 3'd1, 32'hFFFF_FFF0, 0, 0, 0);
      chk("br_neg_const", bus.pc, 32'hF0);
      step("jalr",    0, 0, 3'd2, 0, 32'h2001, 0, 0);
      chk("jalr_const", bus.pc, 32'h2000);

      // misaligned branch redirects to trap_vec, one-cycle flag
      step("trap10",  0, 0, 3'd3, 0, 0, 32'h10, 0);
      step("br_mis",  0, 0, 3'd1, 32'h2, 0, 32'h800, 0);
      chk("br_mis_const", {31'b0, bus.misalign}, 32'h1);
      step("mis_off", 0, 0, 3'd0, 0, 0, 0, 0);

      // stall holds through a pending branch
      step("stall1",  0, 1, 3'd1, 32'h40, 0, 0, 0);
      step("stall2",  0, 1, 3'd1, 32'h40, 0, 0, 0);
      step("stall3",  0, 1, 3'd1, 32'h40, 0, 0, 0);
      step("unstall", 0, 0, 3'd1, 32'h40, 0, 0, 0);
      chk("unstall_const", bus.pc, 32'h844);

      // misaligned trap_vec is taken silently; the next INC is then misaligned
      step("trap_odd", 0, 0, 3'd3, 0, 0, 32'h802, 0);
      step("inc_odd",  0, 0, 3'd0, 0, 0, 32'h900, 0);

      // wrap-around is not an error
      step("trapwrap", 0, 0, 3'd3, 0, 0, 32'hFFFF_FFFC, 0);
      step("wrap",     0, 0, 3'd0, 0, 0, 0, 0);
      chk("wrap_const", bus.pc, 32'h0);

      // unused encodings act as INC
      step("sel5", 0, 0, 3'd5, 32'h100, 0, 0, 0);
      step("sel6", 0, 0, 3'd6, 32'h100, 0, 0, 0);
      step("sel7", 0, 0, 3'd7, 32'h100, 0, 0, 0);

      // five pushes over depth 4, then five RETs (last one underflows)
      step("rst2",  1, 0, 3'd0, 0, 0, 0, 0);
      step("push0", 0, 0, 3'd3, 0, 0, 32'h10, 1);
      step("push1", 0, 0, 3'd3, 0, 0, 32'h20, 1);
      step("push2", 0, 0, 3'd3, 0, 0, 32'h30, 1);
      step("push3", 0, 0, 3'd3, 0, 0, 32'h40, 1);
      step("push4", 0, 0, 3'd3, 0, 0, 32'h100, 1);
      for (int i = 0; i < 5; i++) step($sformatf("ret%0d", i), 0, 0, 3'd4, 0, 0, 0, 0);

      // RET with push replaces top; reset under stall discards the stack
      step("push5",   0, 0, 3'd0, 0, 0, 0, 1);
      step("retpush", 0, 0, 3'd4, 0, 0, 0, 1);
      step("retpop",  0, 0, 3'd4, 0, 0, 0, 0);
      step("push6",   0, 0, 3'd0, 0, 0, 0, 1);
      step("rst_st",  1, 1, 3'd1, 32'h40, 0, 0, 1);
      step("ret_emp", 0, 0, 3'd4, 0, 0, 0, 0);

      // randomized traffic against the reference
      for (int i = 0; i < 400; i++) begin
         sel = 3'($urandom_range(0, 7));
         imm = $urandom;
         if ($urandom_range(0, 7) != 0) imm[1:0] = 2'b00;
         step($sformatf("rnd%0d", i),
              ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 5) == 0),
              sel, imm, $urandom, $urandom & 32'hFFFF_FFFC,
              1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter PC_WIDTH, default 32, width of all PC/address signals.
REQ-002 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 stall  input  1  hold PC and all internal state this cycle.
REQ-007 pc_sel  input  pc_sel_t (3)  next-PC source: INC, BRANCH, JALR, TRAP, RET.
REQ-008 imm_op  input  PC_WIDTH  sign-extended offset for BRANCH/JALR.
REQ-009 rs1_val  input  PC_WIDTH  base register value for JALR.
REQ-010 trap_vec  input  PC_WIDTH  trap handler address.
REQ-011 ras_push  input  1  current instruction is a call; push PC+4.
REQ-012 pc  output  PC_WIDTH  current program counter.
REQ-013 pc_plus4  output  PC_WIDTH  pc+4, combinational, link value.
REQ-014 misalign  output  1  registered one-cycle pulse: last selected target was misaligned.
REQ-015 ras_underflow  output  1  registered one-cycle pulse: RET popped an empty stack.

Function
REQ-016 Targets: INC=pc+4; BRANCH=pc+imm_op; JALR=(rs1_val+imm_op) with bit0 cleared; TRAP=trap_vec; RET=RAS top.
REQ-017 All additions SHALL be modulo 2^PC_WIDTH; wrap-around is not an error.
REQ-018 When stall=0, pc SHALL load the selected target on the next rising edge (one-cycle latency).
REQ-019 When stall=1, pc, RAS contents, RAS count, misalign and ras_underflow SHALL hold/clear as follows: pc and RAS hold, both pulse outputs go 0.
REQ-020 If selected target bits[1:0]!=0 (non-TRAP), pc SHALL load trap_vec instead and misalign SHALL be 1 in the following cycle.
REQ-021 A misaligned trap_vec SHALL be loaded as-is without asserting misalign.
REQ-022 ras_push with stall=0 SHALL push pc_plus4; when full, the oldest entry is overwritten and count stays RAS_DEPTH.
REQ-023 RET with non-empty stack SHALL load top and decrement count.
REQ-024 RET with empty stack SHALL load pc+4 and pulse ras_underflow next cycle.
REQ-025 RET with ras_push in the same cycle SHALL load the old top and replace it with pc_plus4; count unchanged.
REQ-026 ras_push with pc_sel other than RET SHALL push regardless of selected source (including TRAP).
REQ-027 Unused pc_sel encodings SHALL behave as INC.

Reset
REQ-028 On rst=1 at a rising edge: pc=RESET_VECTOR, RAS count=0, misalign=0, ras_underflow=0; rst overrides stall.
REQ-029 Reset asserted mid-operation SHALL discard all RAS contents; RAS entry storage need not be cleared.

Configuration
REQ-030 Macro PC_UNIT_RAS_EN: when defined, RAS logic and RET behaviour per REQ-022..026 are built.
REQ-031 Without PC_UNIT_RAS_EN: no RAS storage; RET behaves as INC; ras_push ignored; ras_underflow tied 0; ports unchanged.

Structure
REQ-032 Package pc_pkg SHALL hold pc_sel_t enum (INC=0, BRANCH=1, JALR=2, TRAP=3, RET=4) and constant PC_INC=4.
REQ-033 The stack SHALL be sub-module pc_ras (push, pop, top, empty, count), instantiated only under PC_UNIT_RAS_EN.

Verification
REQ-034 Reset then 3 cycles INC -> pc = 0, 4, 8, 12.
REQ-035 pc=0x100, BRANCH imm=0xFFFFFFF0 -> pc=0xF0; JALR rs1=0x2001 imm=0 -> pc=0x2000.
REQ-036 pc=0x10, BRANCH imm=0x2, trap_vec=0x800 -> pc=0x800, misalign=1 for exactly one cycle.
REQ-037 stall=1 for 3 cycles with pc_sel=BRANCH -> pc unchanged, then stall=0 -> branch target taken once.
REQ-038 Five pushes at pc=0x0,0x10,0x20,0x30,0x40 (depth 4), then 5 RET -> targets 0x44,0x34,0x24,0x14, fifth RET gives pc+4 and ras_underflow=1.
REQ-039 pc=0xFFFFFFFC, INC -> pc=0x0, no flags.
